// File: rtl/blackjack_mem_pkg.sv
// rtl/blackjack_mem_pkg.sv - shared constants and types for the card memory arbiter
package blackjack_mem_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 13;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] card_word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic              req_id_t;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with registered priority pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  // Grant the lone requester, or the pointed-to one on contention; nothing when disabled.
  always_comb begin
    grant = 2'b00;
    if (advance) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // After a grant to requester i, priority moves to the other requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/hand_mem_arbiter.sv
// rtl/hand_mem_arbiter.sv - player/dealer card memory arbiter; HAND_MEM_INIT_EN enables post-reset clear sweep
module hand_mem_arbiter #(
  parameter int ADDR_W = blackjack_mem_pkg::ADDR_W,
  parameter int DATA_W = blackjack_mem_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                mem_enW,
  output logic [ADDR_W-1:0]   mem_addrW,
  output logic [DATA_W-1:0]   mem_dataW,
  output logic [ADDR_W-1:0]   mem_addrR,
  input  logic [DATA_W-1:0]   mem_dataR
);

  import blackjack_mem_pkg::*;

  logic [1:0]        grant;
  logic              prio_ptr;
  logic              arb_en;
  logic              sweep_wr;
  logic [ADDR_W-1:0] sweep_addr;
  req_id_t           win_id;
  logic              win_write;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              xfer;
  logic              s1_valid;
  req_id_t           s1_id;
  logic              s2_valid;
  req_id_t           s2_id;

`ifdef HAND_MEM_INIT_EN
  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              sweep_last;

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave INIT once the last address is on the write port.
  always_comb begin
    state_d = state_q;
    if (state_q == INIT && sweep_last) begin
      state_d = ARB;
    end
  end

  // Sweep counter walks every address once; sweep_last marks the final write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt  <= '0;
      sweep_last <= 1'b0;
    end else if (state_q == INIT && !sweep_last) begin
      sweep_cnt  <= sweep_cnt + 1'b1;
      sweep_last <= (sweep_cnt == {ADDR_W{1'b1}});
    end
  end

  assign arb_en     = (state_q == ARB);
  assign sweep_wr   = (state_q == INIT) && !sweep_last;
  assign sweep_addr = sweep_cnt;
`else
  assign arb_en     = 1'b1;
  assign sweep_wr   = 1'b0;
  assign sweep_addr = '0;
`endif

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (arb_en),
    .grant   (grant),
    .ptr     (prio_ptr)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign win_id    = (&req_valid) ? prio_ptr : req_valid[1];
  assign win_write = win_id ? req_write[1] : req_write[0];
  assign win_addr  = win_id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign win_wdata = win_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  // Register memory ports and the read tag pipeline from the winning request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_enW   <= 1'b0;
      mem_addrW <= '0;
      mem_dataW <= '0;
      mem_addrR <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= 1'b0;
      s2_valid  <= 1'b0;
      s2_id     <= 1'b0;
    end else begin
      mem_enW <= 1'b0;
      if (sweep_wr) begin
        mem_enW   <= 1'b1;
        mem_addrW <= sweep_addr;
        mem_dataW <= '0;
      end else if (xfer && win_write) begin
        mem_enW   <= 1'b1;
        mem_addrW <= win_addr;
        mem_dataW <= win_wdata;
      end
      if (xfer && !win_write) begin
        mem_addrR <= win_addr;
      end
      s1_valid <= xfer && !win_write;
      s1_id    <= win_id;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
    end
  end

  assign rsp_valid = {s2_valid & s2_id, s2_valid & ~s2_id};
  assign rsp_rdata = s2_valid ? mem_dataR : '0;

endmodule

// File: tb/tb_hand_mem_arbiter.sv
// tb/tb_hand_mem_arbiter.sv - directed self-checking bench for hand_mem_arbiter
module tb_hand_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 13;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          mem_enW;
  logic [AW-1:0] mem_addrW;
  logic [DW-1:0] mem_dataW;
  logic [AW-1:0] mem_addrR;
  logic [DW-1:0] mem_dataR;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp;
  int n_err;

  hand_mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_enW   (mem_enW),
    .mem_addrW (mem_addrW),
    .mem_dataW (mem_dataW),
    .mem_addrR (mem_addrR),
    .mem_dataR (mem_dataR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_enW) mem[mem_addrW] <= mem_dataW;
    mem_dataR <= mem[mem_addrR];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_valid = v;
    req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  {30'd0, req_ready}, 32'h0);
    check({tag, "_rspv"},   {30'd0, rsp_valid}, 32'h0);
    check({tag, "_rdata"},  {19'd0, rsp_rdata}, 32'h0);
    check({tag, "_enw"},    {31'd0, mem_enW},   32'h0);
    check({tag, "_addrw"},  {28'd0, mem_addrW}, 32'h0);
    check({tag, "_dataw"},  {19'd0, mem_dataW}, 32'h0);
    check({tag, "_addrr"},  {28'd0, mem_addrR}, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 13'd0, 13'd0);
    #3;
    check_reset_outputs("rst");
    next_cycle;
    next_cycle;
    rst_n = 1'b1;

`ifdef HAND_MEM_INIT_EN
    drive(2'b11, 2'b00, 4'd0, 4'd0, 13'd0, 13'd0);
    @(negedge clk);
    check("init_ready_c0", {30'd0, req_ready}, 32'h0);
    for (int c = 1; c <= 16; c++) begin
      next_cycle;
      @(negedge clk);
      check("init_enw",   {31'd0, mem_enW},   32'h1);
      check("init_addrw", {28'd0, mem_addrW}, 32'(c - 1));
      check("init_dataw", {19'd0, mem_dataW}, 32'h0);
      check("init_ready", {30'd0, req_ready}, 32'h0);
    end
    next_cycle;
    @(negedge clk);
    check("init_ready_c17", {30'd0, req_ready}, 32'h1);
    check("init_enw_c17",   {31'd0, mem_enW},   32'h0);
    next_cycle;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 13'd0, 13'd0);
    for (int i = 0; i < 4; i++) next_cycle;
`endif

    // single write then read from requester 0
    drive(2'b01, 2'b01, 4'd3, 4'd0, 13'h0A5, 13'd0);
    @(negedge clk);
    check("wr_ready", {30'd0, req_ready}, 32'h1);
    next_cycle;
    drive(2'b01, 2'b00, 4'd3, 4'd0, 13'd0, 13'd0);
    @(negedge clk);
    check("rd_ready", {30'd0, req_ready}, 32'h1);
    check("wr_enw",   {31'd0, mem_enW},   32'h1);
    check("wr_addrw", {28'd0, mem_addrW}, 32'h3);
    check("wr_dataw", {19'd0, mem_dataW}, 32'h0A5);
    next_cycle;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 13'd0, 13'd0);
    @(negedge clk);
    check("rd_enw0",  {31'd0, mem_enW},   32'h0);
    check("rd_addrr", {28'd0, mem_addrR}, 32'h3);
    check("rd_rspv0", {30'd0, rsp_valid}, 32'h0);
    next_cycle;
    @(negedge clk);
    check("rd_rspv",  {30'd0, rsp_valid}, 32'h1);
    check("rd_rdata", {19'd0, rsp_rdata}, 32'h0A5);

    // preload: req0 writes addr1, req1 writes addr2; pointer ends at 0
    next_cycle;
    drive(2'b01, 2'b01, 4'd1, 4'd0, 13'h011, 13'd0);
    @(negedge clk);
    check("pre0_ready", {30'd0, req_ready}, 32'h1);
    next_cycle;
    drive(2'b10, 2'b10, 4'd0, 4'd2, 13'd0, 13'h022);
    @(negedge clk);
    check("pre1_ready", {30'd0, req_ready}, 32'h2);
    next_cycle;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 13'd0, 13'd0);

    // idle hold
    for (int i = 0; i < 5; i++) begin
      next_cycle;
      @(negedge clk);
      check("idle_enw",  {31'd0, mem_enW},   32'h0);
      check("idle_rspv", {30'd0, rsp_valid}, 32'h0);
    end
    check("idle_ptr", {31'd0, dut.u_arb.ptr}, 32'h0);

    // contention: both read continuously
    for (int k = 0; k < 8; k++) begin
      next_cycle;
      if (k < 6) drive(2'b11, 2'b00, 4'd1, 4'd2, 13'd0, 13'd0);
      else       drive(2'b00, 2'b00, 4'd0, 4'd0, 13'd0, 13'd0);
      @(negedge clk);
      if (k < 6) check("cont_ready", {30'd0, req_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k >= 2) begin
        check("cont_rspv",  {30'd0, rsp_valid}, (k % 2 == 0) ? 32'h1 : 32'h2);
        check("cont_rdata", {19'd0, rsp_rdata}, (k % 2 == 0) ? 32'h011 : 32'h022);
      end
    end

    // mixed op: req0 write addr5, req1 read addr2
    next_cycle;
    drive(2'b11, 2'b01, 4'd5, 4'd2, 13'h155, 13'd0);
    @(negedge clk);
    check("mix_ready0", {30'd0, req_ready}, 32'h1);
    next_cycle;
    drive(2'b10, 2'b00, 4'd5, 4'd2, 13'd0, 13'd0);
    @(negedge clk);
    check("mix_ready1", {30'd0, req_ready}, 32'h2);
    check("mix_enw",    {31'd0, mem_enW},   32'h1);
    check("mix_addrw",  {28'd0, mem_addrW}, 32'h5);
    check("mix_dataw",  {19'd0, mem_dataW}, 32'h155);
    next_cycle;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 13'd0, 13'd0);
    @(negedge clk);
    check("mix_rspv0",  {30'd0, rsp_valid}, 32'h0);
    check("mix_addrr",  {28'd0, mem_addrR}, 32'h2);
    next_cycle;
    @(negedge clk);
    check("mix_rspv",   {30'd0, rsp_valid}, 32'h2);
    check("mix_rdata",  {19'd0, rsp_rdata}, 32'h022);

    // async reset one cycle after a read handshake
    next_cycle;
    drive(2'b01, 2'b00, 4'd1, 4'd0, 13'd0, 13'd0);
    @(negedge clk);
    check("rr_ready", {30'd0, req_ready}, 32'h1);
    next_cycle;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 13'd0, 13'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    check("mid_rst_ptr", {31'd0, dut.u_arb.ptr}, 32'h0);
    next_cycle;
    next_cycle;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_rspv", {30'd0, rsp_valid}, 32'h0);
      next_cycle;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
